deal_sequencer: RTL and testbench
=================================

Name: deal_sequencer

Overview:
- Controller that drives the shuffling card deck through one Texas Hold'em hand.
- Requests a shuffle and waits for the deck to report ready.
- Deals hole cards round-robin, then burns and deals flop, turn and river on request from game control.
- Sits between game-control FSM and deck; the only block that toggles deck start_shuffle/draw_card.

Parameters:
- NUM_PLAYERS, 4, seated players; legal range 2..8 (elaboration-time assertion). Max draws per hand = 2*8+3+5 = 24, within 52.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- new_hand  in  1  pulse: start a new hand (shuffle and deal hole cards)
- advance  in  1  pulse: deal next street (flop, turn, river)
- deck_ready  in  1  deck shuffled and drawable
- deck_top_card  in  card_t  current deck top card (combinational from deck)
- deck_start_shuffle  out  1  to deck start_shuffle
- deck_draw_card  out  1  to deck draw_card
- card_valid  out  1  card_out/card_dest/card_slot valid this cycle
- card_out  out  card_t  dealt card
- card_dest  out  4  0..NUM_PLAYERS-1 = player seat; DEST_BOARD = 8; DEST_BURN = 9
- card_slot  out  3  hole slot 0/1 or board slot 0..4; 0 for burn
- street  out  street_t  PREFLOP, FLOP, TURN, RIVER (street of the last completed deal)
- busy  out  1  high in SHUF_REQ, SHUF_WAIT, DEAL_HOLE, BURN, DEAL_BOARD
- hand_done  out  1  high in DONE

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0; street = PREFLOP.
  - Counters 0.
- FSM states: IDLE, SHUF_REQ, SHUF_WAIT, DEAL_HOLE, WAIT_ADV, BURN, DEAL_BOARD, DONE.
- IDLE: new_hand -> SHUF_REQ.
- SHUF_REQ:
  - deck_start_shuffle = 1 for exactly this one cycle.
  - Next state SHUF_WAIT unconditionally.
- SHUF_WAIT:
  - Stays until deck_ready = 1, then -> DEAL_HOLE.
  - deck_ready is low from the cycle after start_shuffle, so no stale-ready check is needed.
- DEAL_HOLE:
  - deck_draw_card = 1 every cycle, for 2*NUM_PLAYERS cycles.
  - Draw k (0-based) goes to seat k mod NUM_PLAYERS, slot k / NUM_PLAYERS.
  - After the last draw -> WAIT_ADV, street = PREFLOP.
- WAIT_ADV:
  - advance -> BURN.
  - If street == RIVER, go to DONE instead of WAIT_ADV.
- BURN:
  - One draw cycle.
  - card_valid stays 0 (see optional feature).
  - -> DEAL_BOARD.
- DEAL_BOARD:
  - Draws 3 cards (next street FLOP, slots 0..2), 1 card (TURN, slot 3) or 1 card (RIVER, slot 4).
  - street updates on the last board draw.
  - Then -> WAIT_ADV, or -> DONE after RIVER.
- DONE: hold until new_hand.
- Output timing:
  - card_valid/card_out/card_dest/card_slot are registered.
  - They assert the cycle after the draw cycle, carrying deck_top_card sampled in the draw cycle.
  - Single-cycle pulse per card; back-to-back draws give back-to-back valids.
- Input acceptance:
  - new_hand is accepted only in IDLE, WAIT_ADV and DONE. In WAIT_ADV it abandons the hand and goes to SHUF_REQ with counters cleared.
  - new_hand is ignored in busy states.
  - advance is ignored outside WAIT_ADV.
  - new_hand and advance in the same cycle in WAIT_ADV: new_hand wins.
- Reset mid-deal:
  - Returns to IDLE next cycle; no further draw_card or valid pulses.
  - The deck is reset by the same reset.

Optional Feature:
- Macro DEAL_BURN_VISIBLE_EN.
- Defined: burn cards emit card_valid = 1 with card_dest = DEST_BURN and card_slot = 0 (for audit/display logic).
- Undefined: burn draws still occur but card_valid stays 0 for them; DEST_BURN is never driven.

Decomposition:
- poker_types package (existing): card_t, rank_t, suit_t.
- Add to poker_types: street_t enum; DEST_BOARD and DEST_BURN constants; MAX_PLAYERS = 8.
- One natural sub-module: deal_slot_counter. It tracks seat/slot round-robin (seat wraps at NUM_PLAYERS, slot increments on wrap) and resets per street.

Test Plan:
- NUM_PLAYERS=3, deck model with ready after 52 cycles: new_hand -> exactly one deck_start_shuffle pulse. Then 6 consecutive draw_card pulses; valid dests 0,1,2,0,1,2 with slots 0,0,0,1,1,1; street=PREFLOP; busy drops.
- advance in WAIT_ADV -> 1 burn draw with no valid, then 3 valids dest=8 slots 0,1,2; street=FLOP. Second advance -> burn plus slot 3, TURN. Third -> burn plus slot 4, RIVER, hand_done=1. Total draws 14.
- advance during DEAL_HOLE and during SHUF_WAIT -> ignored: no extra draw, card sequence unchanged.
- new_hand and advance in the same cycle in WAIT_ADV after FLOP -> new shuffle pulse, slot counters restart at seat 0 slot 0, no board card dealt.
- reset asserted on the 3rd hole draw -> state IDLE next cycle; draw_card, card_valid, busy all 0; street=PREFLOP.
- With DEAL_BURN_VISIBLE_EN, NUM_PLAYERS=2: flop advance -> valids dest 9/slot 0, then 8/0, 8/1, 8/2, each card_out equal to the model deck's sequential top card.

Source files
------------

// File: rtl/poker_types.sv
// Shared poker types: cards, streets, deal destinations and the sequencer state encoding.
// Used by deal_sequencer, its interface and its seat/slot counter.
package poker_types;

    typedef enum logic [1:0] {
        SUIT_CLUBS,
        SUIT_DIAMONDS,
        SUIT_HEARTS,
        SUIT_SPADES
    } suit_t;

    // Ranks 2..14 (ace high); 0, 1 and 15 are unused encodings.
    typedef logic [3:0] rank_t;

    typedef struct packed {
        suit_t suit;
        rank_t rank;
    } card_t;

    // Street of the last completed deal.
    typedef enum logic [1:0] {
        PREFLOP,
        FLOP,
        TURN,
        RIVER
    } street_t;

    localparam int         MAX_PLAYERS = 8;
    localparam logic [3:0] DEST_BOARD  = 4'd8;
    localparam logic [3:0] DEST_BURN   = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHUF_REQ,
        ST_SHUF_WAIT,
        ST_DEAL_HOLE,
        ST_WAIT_ADV,
        ST_BURN,
        ST_DEAL_BOARD,
        ST_DONE
    } deal_state_t;

endpackage

// File: rtl/deal_sequencer_if.sv
// Interface between deal_sequencer, game control and the shuffling deck.
// master: the sequencer side. slave: game control plus deck side.
interface deal_sequencer_if;
    import poker_types::*;

    logic        new_hand;
    logic        advance;
    logic        deck_ready;
    card_t       deck_top_card;
    logic        deck_start_shuffle;
    logic        deck_draw_card;
    logic        card_valid;
    card_t       card_out;
    logic [3:0]  card_dest;
    logic [2:0]  card_slot;
    street_t     street;
    logic        busy;
    logic        hand_done;

    modport master (
        input  new_hand, advance, deck_ready, deck_top_card,
        output deck_start_shuffle, deck_draw_card, card_valid, card_out,
               card_dest, card_slot, street, busy, hand_done
    );

    modport slave (
        output new_hand, advance, deck_ready, deck_top_card,
        input  deck_start_shuffle, deck_draw_card, card_valid, card_out,
               card_dest, card_slot, street, busy, hand_done
    );

endinterface

// File: rtl/deal_slot_counter.sv
// Round-robin hole-card position: seat wraps at NUM_PLAYERS, slot advances on each wrap.
// Cleared at the start of every hand; last_o flags the final hole draw (last seat, slot 1).
module deal_slot_counter #(
    parameter int NUM_PLAYERS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       step_i,
    output logic [3:0] seat_o,
    output logic [2:0] slot_o,
    output logic       last_o
);

    localparam logic [3:0] LAST_SEAT = 4'(NUM_PLAYERS - 1);

    logic [3:0] seat_q;
    logic [2:0] slot_q;

    // Seat/slot register: clear wins over step.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset || clear_i) begin
            seat_q <= '0;
            slot_q <= '0;
        end else if (step_i) begin
            if (seat_q == LAST_SEAT) begin
                seat_q <= '0;
                slot_q <= slot_q + 3'd1;
            end else begin
                seat_q <= seat_q + 4'd1;
            end
        end
    end

    assign seat_o = seat_q;
    assign slot_o = slot_q;
    assign last_o = (seat_q == LAST_SEAT) && (slot_q == 3'd1);

endmodule

// File: rtl/deal_sequencer.sv
// Drives the shuffling deck through one Texas Hold'em hand: shuffle, hole cards,
// then burn + flop/turn/river on each advance request.
// Optional macro DEAL_BURN_VISIBLE_EN: burn cards are reported with card_dest = DEST_BURN.
module deal_sequencer
    import poker_types::*;
#(
    parameter int NUM_PLAYERS = 4
) (
    input logic              clk,
    input logic              reset,
    deal_sequencer_if.master bus
);

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > MAX_PLAYERS) begin : g_bad_players
        $error("deal_sequencer: NUM_PLAYERS must be in 2..8");
    end

    deal_state_t state_q, state_d;
    street_t     street_q, street_d;
    logic [2:0]  board_slot_q, board_slot_d;

    logic        card_valid_q, card_valid_d;
    card_t       card_out_q, card_out_d;
    logic [3:0]  card_dest_q, card_dest_d;
    logic [2:0]  card_slot_q, card_slot_d;

    logic        accept_new;
    logic        hole_step;
    logic        draw;
    logic        shuffle;
    logic [3:0]  hole_seat;
    logic [2:0]  hole_slot;
    logic        hole_last;

    // new_hand is honoured only where a hand may legally be abandoned or started.
    assign accept_new = bus.new_hand &&
                        (state_q == ST_IDLE || state_q == ST_WAIT_ADV || state_q == ST_DONE);

    deal_slot_counter #(
        .NUM_PLAYERS(NUM_PLAYERS)
    ) u_slot_counter (
        .clk    (clk),
        .reset  (reset),
        .clear_i(accept_new),
        .step_i (hole_step),
        .seat_o (hole_seat),
        .slot_o (hole_slot),
        .last_o (hole_last)
    );

    // Next-state, deck strobes and next card-report values.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        street_d     = street_q;
        board_slot_d = board_slot_q;
        card_valid_d = 1'b0;
        card_out_d   = card_out_q;
        card_dest_d  = card_dest_q;
        card_slot_d  = card_slot_q;
        hole_step    = 1'b0;
        draw         = 1'b0;
        shuffle      = 1'b0;

        if (accept_new) begin
            state_d      = ST_SHUF_REQ;
            street_d     = PREFLOP;
            board_slot_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_SHUF_REQ: begin
                    shuffle = 1'b1;
                    state_d = ST_SHUF_WAIT;
                end
                ST_SHUF_WAIT: begin
                    if (bus.deck_ready) state_d = ST_DEAL_HOLE;
                end
                ST_DEAL_HOLE: begin
                    draw         = 1'b1;
                    hole_step    = 1'b1;
                    card_valid_d = 1'b1;
                    card_out_d   = bus.deck_top_card;
                    card_dest_d  = hole_seat;
                    card_slot_d  = hole_slot;
                    if (hole_last) begin
                        state_d  = ST_WAIT_ADV;
                        street_d = PREFLOP;
                    end
                end
                ST_WAIT_ADV: begin
                    if (bus.advance) state_d = ST_BURN;
                end
                ST_BURN: begin
                    draw = 1'b1;
`ifdef DEAL_BURN_VISIBLE_EN
                    card_valid_d = 1'b1;
                    card_out_d   = bus.deck_top_card;
                    card_dest_d  = DEST_BURN;
                    card_slot_d  = 3'd0;
`else
                    card_valid_d = 1'b0;
`endif
                    state_d = ST_DEAL_BOARD;
                end
                ST_DEAL_BOARD: begin
                    draw         = 1'b1;
                    card_valid_d = 1'b1;
                    card_out_d   = bus.deck_top_card;
                    card_dest_d  = DEST_BOARD;
                    card_slot_d  = board_slot_q;
                    board_slot_d = board_slot_q + 3'd1;
                    // Board slots 2, 3 and 4 close the flop, turn and river.
                    case (board_slot_q)
                        3'd2: begin
                            street_d = FLOP;
                            state_d  = ST_WAIT_ADV;
                        end
                        3'd3: begin
                            street_d = TURN;
                            state_d  = ST_WAIT_ADV;
                        end
                        3'd4: begin
                            street_d = RIVER;
                            state_d  = ST_DONE;
                        end
                        default: ;
                    endcase
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, street and registered card report.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            street_q     <= PREFLOP;
            board_slot_q <= '0;
            card_valid_q <= 1'b0;
            card_out_q   <= '0;
            card_dest_q  <= '0;
            card_slot_q  <= '0;
        end else begin
            state_q      <= state_d;
            street_q     <= street_d;
            board_slot_q <= board_slot_d;
            card_valid_q <= card_valid_d;
            card_out_q   <= card_out_d;
            card_dest_q  <= card_dest_d;
            card_slot_q  <= card_slot_d;
        end
    end

    assign bus.deck_start_shuffle = shuffle;
    assign bus.deck_draw_card     = draw;
    assign bus.card_valid         = card_valid_q;
    assign bus.card_out           = card_out_q;
    assign bus.card_dest          = card_dest_q;
    assign bus.card_slot          = card_slot_q;
    assign bus.street             = street_q;
    assign bus.busy               = (state_q == ST_SHUF_REQ)  || (state_q == ST_SHUF_WAIT) ||
                                    (state_q == ST_DEAL_HOLE) || (state_q == ST_BURN) ||
                                    (state_q == ST_DEAL_BOARD);
    assign bus.hand_done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer with NUM_PLAYERS = 3 and a behavioural deck.
// Deck card k after a shuffle encodes as 6'(k + 5). Burn expectations follow DEAL_BURN_VISIBLE_EN.
module tb_deal_sequencer;
    import poker_types::*;

`ifdef DEAL_BURN_VISIBLE_EN
    localparam int BURN_VIS = 1;
`else
    localparam int BURN_VIS = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    deal_sequencer_if bus ();

    deal_sequencer #(
        .NUM_PLAYERS(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Deck model: ready 52 cycles after a shuffle request, top index advances per draw.
    logic [5:0] deck_idx;
    logic [6:0] deck_cnt;
    logic       deck_ready;
    always @(posedge clk) begin
        if (reset) begin
            deck_ready <= 1'b0;
            deck_idx   <= '0;
            deck_cnt   <= '0;
        end else if (bus.deck_start_shuffle) begin
            deck_ready <= 1'b0;
            deck_idx   <= '0;
            deck_cnt   <= 7'd52;
        end else begin
            if (deck_cnt != 0) deck_cnt <= deck_cnt - 7'd1;
            if (deck_cnt == 7'd1) deck_ready <= 1'b1;
            if (bus.deck_draw_card) deck_idx <= deck_idx + 6'd1;
        end
    end
    assign bus.deck_ready    = deck_ready;
    assign bus.deck_top_card = card_t'(deck_idx + 6'd5);

    // Monitor: counts strobes and records every reported card.
    int         n_shuf  = 0;
    int         n_draws = 0;
    logic [3:0] q_dest[$];
    logic [2:0] q_slot[$];
    logic [5:0] q_card[$];
    always @(negedge clk) begin
        if (bus.deck_start_shuffle) n_shuf++;
        if (bus.deck_draw_card) n_draws++;
        if (bus.card_valid) begin
            q_dest.push_back(bus.card_dest);
            q_slot.push_back(bus.card_slot);
            q_card.push_back(6'(bus.card_out));
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int p        = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_new();
        @(negedge clk) bus.new_hand = 1'b1;
        @(negedge clk) bus.new_hand = 1'b0;
    endtask

    task automatic pulse_adv();
        @(negedge clk) bus.advance = 1'b1;
        @(negedge clk) bus.advance = 1'b0;
    endtask

    // Wait for busy to drop, then let the last registered card reach the monitor.
    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_draw(input string tag);
        int n = 0;
        while (!bus.deck_draw_card && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.deck_draw_card), 32'd1);
    endtask

    // Advance one street; board cards start at deck index base+1 after the burn at base.
    task automatic deal_street(input string tag, input int first_slot, input int nboard,
                               input street_t exp_street, input int base);
        int nv = nboard + BURN_VIS;
        pulse_adv();
        wait_idle({tag, "_idle"});
        check({tag, "_count"}, 32'(q_dest.size()), 32'(p + nv));
        for (int j = 0; j < nv; j++) begin
            int is_burn = (BURN_VIS == 1 && j == 0) ? 1 : 0;
            check({tag, "_dest"}, 32'(q_dest[p + j]), is_burn ? 32'(DEST_BURN) : 32'(DEST_BOARD));
            check({tag, "_slot"}, 32'(q_slot[p + j]), is_burn ? 32'd0 : 32'(first_slot + j - BURN_VIS));
            check({tag, "_card"}, 32'(q_card[p + j]), 32'(base + j + 1 - BURN_VIS + 5));
        end
        check({tag, "_street"}, 32'(bus.street), 32'(exp_street));
        p += nv;
    endtask

    initial begin
        int d_snap;
        bus.new_hand = 1'b0;
        bus.advance  = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.hand_done), 32'd0);
        check("rst_valid", 32'(bus.card_valid), 32'd0);
        check("rst_shuffle", 32'(bus.deck_start_shuffle), 32'd0);
        check("rst_draw", 32'(bus.deck_draw_card), 32'd0);
        check("rst_street", 32'(bus.street), 32'(PREFLOP));

        // Hand 1: shuffle, ignored advances in SHUF_WAIT and DEAL_HOLE, hole cards
        pulse_new();
        repeat (5) @(negedge clk);
        check("shufwait_busy", 32'(bus.busy), 32'd1);
        pulse_adv();
        wait_draw("h1_first_draw");
        bus.advance = 1'b1;
        @(negedge clk) bus.advance = 1'b0;
        wait_idle("h1_hole_idle");
        check("h1_shuffles", 32'(n_shuf), 32'd1);
        check("h1_hole_draws", 32'(n_draws), 32'd6);
        check("h1_hole_count", 32'(q_dest.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check("h1_hole_dest", 32'(q_dest[k]), 32'(k % 3));
            check("h1_hole_slot", 32'(q_slot[k]), 32'(k / 3));
            check("h1_hole_card", 32'(q_card[k]), 32'(k + 5));
        end
        check("h1_street_pre", 32'(bus.street), 32'(PREFLOP));
        check("h1_not_done", 32'(bus.hand_done), 32'd0);
        p = 6;

        // Flop, turn, river
        deal_street("flop", 0, 3, FLOP, 6);
        check("flop_draws", 32'(n_draws), 32'd10);
        deal_street("turn", 3, 1, TURN, 10);
        check("turn_draws", 32'(n_draws), 32'd12);
        deal_street("river", 4, 1, RIVER, 12);
        check("river_draws", 32'(n_draws), 32'd14);
        check("river_done", 32'(bus.hand_done), 32'd1);

        // DONE holds; advance ignored
        pulse_adv();
        repeat (3) @(negedge clk);
        check("done_hold", 32'(bus.hand_done), 32'd1);
        check("done_no_draw", 32'(n_draws), 32'd14);
        check("done_no_card", 32'(q_dest.size()), 32'(p));

        // Hand 2 from DONE, then flop
        pulse_new();
        wait_idle("h2_hole_idle");
        check("h2_shuffles", 32'(n_shuf), 32'd2);
        check("h2_hole_count", 32'(q_dest.size()), 32'(p + 6));
        check("h2_first_dest", 32'(q_dest[p]), 32'd0);
        check("h2_last_dest", 32'(q_dest[p + 5]), 32'd2);
        check("h2_last_slot", 32'(q_slot[p + 5]), 32'd1);
        check("h2_last_card", 32'(q_card[p + 5]), 32'd10);
        p += 6;
        deal_street("h2_flop", 0, 3, FLOP, 6);

        // new_hand and advance together in WAIT_ADV: new_hand wins
        @(negedge clk);
        bus.new_hand = 1'b1;
        bus.advance  = 1'b1;
        @(negedge clk);
        bus.new_hand = 1'b0;
        bus.advance  = 1'b0;
        wait_idle("both_idle");
        check("both_shuffles", 32'(n_shuf), 32'd3);
        check("both_count", 32'(q_dest.size()), 32'(p + 6));
        check("both_dest0", 32'(q_dest[p]), 32'd0);
        check("both_slot0", 32'(q_slot[p]), 32'd0);
        check("both_card0", 32'(q_card[p]), 32'd5);
        check("both_street", 32'(bus.street), 32'(PREFLOP));
        p += 6;

        // Reset on the third hole draw
        pulse_new();
        wait_draw("h4_first_draw");
        @(negedge clk);
        @(negedge clk);
        check("h4_third_draw", 32'(bus.deck_draw_card), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        d_snap = n_draws;
        check("midrst_draw", 32'(bus.deck_draw_card), 32'd0);
        check("midrst_valid", 32'(bus.card_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.hand_done), 32'd0);
        check("midrst_street", 32'(bus.street), 32'(PREFLOP));
        repeat (4) @(negedge clk);
        check("midrst_no_more_draws", 32'(n_draws), 32'(d_snap));
        check("midrst_cards", 32'(q_dest.size()), 32'(p + 2));
        check("midrst_idle_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
